// File: rtl/solver_dispatch.sv
// Job dispatcher for a pool of fractal solver cores: allocates an idle core, streams its
// configuration and c limbs over a shared write bus, and merges finished counts round-robin.
//
// state   | meaning
// IDLE    | wait for a job descriptor; zero-limb jobs are dropped here
// CFG     | write num_limbs / iteration limit into target core, mark it busy
// LOAD_RE | stream real limbs 0..n-1 into target core
// LOAD_IM | stream imaginary limbs 0..n-1 into target core
// START   | pulse start on target core
module solver_dispatch #(
    parameter int NUM_SOLVERS     = 4,
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32,
    parameter int ID_BITS         = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [ID_BITS-1:0]         job_id,
    input  logic [LIMB_INDEX_BITS-1:0] job_num_limbs,
    input  logic [15:0]                job_iter_lim,
    input  logic                       limb_valid,
    output logic                       limb_ready,
    input  logic [LIMB_BITS-1:0]       limb_data,
    output logic [LIMB_INDEX_BITS-1:0] s_wr_ind,
    output logic [LIMB_BITS-1:0]       s_wr_data,
    output logic [LIMB_INDEX_BITS-1:0] s_num_limbs_data,
    output logic [15:0]                s_iter_lim_data,
    output logic [NUM_SOLVERS-1:0]     s_wr_real_en,
    output logic [NUM_SOLVERS-1:0]     s_wr_imag_en,
    output logic [NUM_SOLVERS-1:0]     s_wr_num_limbs_en,
    output logic [NUM_SOLVERS-1:0]     s_wr_iter_lim_en,
    output logic [NUM_SOLVERS-1:0]     s_start,
    input  logic [NUM_SOLVERS-1:0]     s_out_ready,
    input  logic [16*NUM_SOLVERS-1:0]  s_iteration_count,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ID_BITS-1:0]         res_id,
    output logic [15:0]                res_count,
    output logic [NUM_SOLVERS-1:0]     busy_mask,
    output logic                       drop_pulse
);

    localparam int PTR_BITS = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

    typedef enum logic [2:0] {IDLE, CFG, LOAD_RE, LOAD_IM, START} state_t;

    state_t                     state, state_nxt;
    logic [NUM_SOLVERS-1:0]     busy, armed, done;
    logic [ID_BITS-1:0]         tag [NUM_SOLVERS];
    logic [PTR_BITS-1:0]        rr_ptr, tgt, free_idx, grant_idx, res_core;
    logic [PTR_BITS-1:0]        hi_idx, lo_idx;
    logic                       any_free, hi_hit, lo_hit;
    logic [ID_BITS-1:0]         cur_id;
    logic [LIMB_INDEX_BITS-1:0] cur_n, cnt;
    logic [15:0]                cur_lim;
    logic                       job_hs, limb_hs, res_hs, last_limb;

    assign job_ready  = reset & (state == IDLE) & any_free;
    assign limb_ready = reset & ((state == LOAD_RE) || (state == LOAD_IM));
    assign job_hs     = job_valid & job_ready;
    assign limb_hs    = limb_valid & limb_ready;
    assign res_hs     = res_valid & res_ready;
    assign drop_pulse = job_hs & (job_num_limbs == '0);
    assign last_limb  = (cnt == cur_n - LIMB_INDEX_BITS'(1));

    assign s_wr_ind         = cnt;
    assign s_wr_data        = limb_ready ? limb_data : '0;
    assign s_num_limbs_data = cur_n;
    assign s_iter_lim_data  = cur_lim;
    assign busy_mask        = busy;
    assign done             = busy & armed & s_out_ready;

    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int k = NUM_SOLVERS - 1; k >= 0; k--) begin
            if (!busy[k]) begin
                free_idx = PTR_BITS'(k);
                any_free = 1'b1;
            end
        end
    end

    // First done core at or above the pointer wins; otherwise wrap to the lowest done core.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int k = NUM_SOLVERS - 1; k >= 0; k--) begin
            if (done[k]) begin
                lo_hit = 1'b1;
                lo_idx = PTR_BITS'(k);
                if (k >= int'(rr_ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = PTR_BITS'(k);
                end
            end
        end
        grant_idx = hi_hit ? hi_idx : lo_idx;
    end

    always_comb begin
        state_nxt         = state;
        s_wr_num_limbs_en = '0;
        s_wr_iter_lim_en  = '0;
        s_wr_real_en      = '0;
        s_wr_imag_en      = '0;
        s_start           = '0;
        case (state)
            IDLE: if (job_hs && job_num_limbs != '0) state_nxt = CFG;
            CFG: begin
                s_wr_num_limbs_en[tgt] = 1'b1;
                s_wr_iter_lim_en[tgt]  = 1'b1;
                state_nxt              = LOAD_RE;
            end
            LOAD_RE: begin
                s_wr_real_en[tgt] = limb_hs;
                if (limb_hs && last_limb) state_nxt = LOAD_IM;
            end
            LOAD_IM: begin
                s_wr_imag_en[tgt] = limb_hs;
                if (limb_hs && last_limb) state_nxt = START;
            end
            START: begin
                s_start[tgt] = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cur_id  <= '0;
            cur_n   <= '0;
            cur_lim <= '0;
            tgt     <= '0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            if (job_hs) begin
                cur_id  <= job_id;
                cur_n   <= job_num_limbs;
                cur_lim <= job_iter_lim;
                tgt     <= free_idx;
            end
            if (limb_hs) cnt <= last_limb ? '0 : cnt + LIMB_INDEX_BITS'(1);
        end
    end

    // armed waits for the core to drop out_ready after start, so a stale done flag is ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy  <= '0;
            armed <= '0;
            for (int k = 0; k < NUM_SOLVERS; k++) tag[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_SOLVERS; k++) begin
                if (res_hs && res_core == PTR_BITS'(k)) begin
                    busy[k]  <= 1'b0;
                    armed[k] <= 1'b0;
                end else begin
                    if (state == CFG && tgt == PTR_BITS'(k)) begin
                        busy[k] <= 1'b1;
                        tag[k]  <= cur_id;
                    end
                    if (state == START && tgt == PTR_BITS'(k)) armed[k] <= 1'b0;
                    else if (busy[k] && !s_out_ready[k])       armed[k] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_count <= '0;
            res_core  <= '0;
            rr_ptr    <= '0;
        end else if (res_hs) begin
            res_valid <= 1'b0;
            rr_ptr    <= (res_core == PTR_BITS'(NUM_SOLVERS - 1)) ? '0 : res_core + PTR_BITS'(1);
        end else if (!res_valid && lo_hit) begin
            res_valid <= 1'b1;
            res_id    <= tag[grant_idx];
            res_count <= s_iteration_count[{grant_idx, 4'h0} +: 16];
            res_core  <= grant_idx;
        end
    end

endmodule
